// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the counter-width helper used to size the bit counter from WIDTH.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit counter must index 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when a borrow is needed.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: accepts a, b, b_in with a valid/ready handshake,
// processes one bit per cycle LSB first, and presents diff/b_out until the
// consumer takes them.
// Optional build macro SERIAL_SUB_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
  logic             accept;
  logic             last_bit;
  logic             bit_d;
  logic             bit_bout;

  full_subtractor u_full_subtractor (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign accept   = start_valid & start_ready;
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; DONE blocks new starts until drained.
  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_ready = 1'b1;
        if (start_valid) state_d = StRun;
      end
      StRun: begin
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        done_valid = 1'b1;
        if (done_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand shifters, borrow chain, bit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
      diff  <= '0;
      b_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      br_q  <= b_in;
      cnt_q <= '0;
    end else if (state_q == StRun) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      br_q  <= bit_bout;
      cnt_q <= cnt_q + CntW'(1);
      res_q <= {bit_d, res_q[WIDTH-1:1]};
      if (last_bit) begin
        diff  <= {bit_d, res_q[WIDTH-1:1]};
        b_out <= bit_bout;
`ifdef SERIAL_SUB_OVF_EN
        // On the last bit the shifter LSBs hold the original operand MSBs.
        ovf   <= (a_q[0] ^ b_q[0]) & (bit_d ^ a_q[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif
  logic         done_valid;
  logic         done_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n;
  int last_acc;
  logic [W-1:0] last_diff;
  vec_t vt[8];
  vec_t rv;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .b_in        (b_in),
    .diff        (diff),
    .b_out       (b_out),
`ifdef SERIAL_SUB_OVF_EN
    .ovf         (ovf),
`endif
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v,
                              input logic [W-1:0] d_v, input logic bo_v, input logic ov_v);
    vec_t v;
    v.a = a_v; v.b = b_v; v.bin = bin_v; v.diff = d_v; v.bout = bo_v; v.ovf = ov_v;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
  task automatic do_op(input vec_t v, input int stall);
    int k;
    check("idle_ready", start_ready, 1);
    a = v.a; b = v.b; b_in = v.bin; start_valid = 1'b1;
    done_ready = (stall == 0);
    @(negedge clk);
    // Scramble inputs; they must be ignored while busy.
    start_valid = 1'b0; a = ~v.a; b = v.b + 1'b1; b_in = ~v.bin;
    check("accept", start_ready, 0);
    check("hold_run", diff, last_diff);
    k = 0;
    while (!done_valid && k < 3 * W) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, W);
    check("diff", diff, v.diff);
    check("b_out", b_out, v.bout);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf, v.ovf);
`endif
    for (int i = 0; i < stall; i++) begin
      start_valid = 1'b1;
      @(negedge clk);
      check("stall_valid", done_valid, 1);
      check("stall_diff", diff, v.diff);
      check("stall_bout", b_out, v.bout);
      check("stall_ready", start_ready, 0);
    end
    if (stall > 0) begin
      // start_valid stays high across the handshake edge and must not be taken.
      done_ready = 1'b1;
      start_valid = 1'b1;
    end
    @(negedge clk);
    start_valid = 1'b0;
    done_ready = 1'b0;
    check("hs_idle", start_ready, 1);
    check("hs_done_low", done_valid, 0);
    check("hs_diff_hold", diff, v.diff);
    last_diff = v.diff;
  endtask

  initial begin
    vt[0] = mk(4'b1101, 4'b1001, 1'b1, 4'b0011, 1'b0, 1'b0);
    vt[1] = mk(4'b0011, 4'b1000, 1'b1, 4'b1010, 1'b1, 1'b1);
    vt[2] = mk(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
    vt[3] = mk(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1);
    vt[4] = mk(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    vt[5] = mk(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    vt[6] = mk(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    vt[7] = mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0);
    rv    = mk(4'b0101, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
    last_diff = '0;

    // Reset state with the clock running.
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", start_ready, 1);
    check("rst_done", done_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", b_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // Table: entry 2 also exercises a 5-cycle consumer stall.
    for (int i = 0; i < 8; i++) begin
      do_op(vt[i], (i == 2) ? 5 : 0);
    end

    // Reset during RUN aborts the operation.
    a = 4'b1111; b = 4'b0001; b_in = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_done", done_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", b_out, 0);
    check("abort_ready", start_ready, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_hold_done", done_valid, 0);
    end
    rst_n = 1'b1;
    last_diff = '0;
    do_op(rv, 0);

    // Back-to-back: start_valid and done_ready held high.
    start_valid = 1'b1; done_ready = 1'b1;
    a = vt[4].a; b = vt[4].b; b_in = vt[4].bin;
    last_acc = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!start_ready && n < 3 * W) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (start_ready && n < 3 * W) begin
        @(negedge clk);
        n++;
      end
      check("b2b_accept", start_ready, 0);
      if (k > 0) check("b2b_period", cyc - last_acc, W + 2);
      last_acc = cyc;
      if (k < 3) begin
        a = vt[5 + k].a; b = vt[5 + k].b; b_in = vt[5 + k].bin;
      end
      n = 0;
      while (!done_valid && n < 3 * W) begin
        @(negedge clk);
        n++;
      end
      check("b2b_latency", n, W);
      check("b2b_diff", diff, vt[4 + k].diff);
      check("b2b_bout", b_out, vt[4 + k].bout);
    end
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_end_ready", start_ready, 1);
    check("b2b_end_done", done_valid, 0);
    check("b2b_end_diff", diff, vt[7].diff);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start_valid  input  1  operands present on a/b/b_in.
REQ-005 Port: start_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  minuend.
REQ-007 Port: b  input  WIDTH  subtrahend.
REQ-008 Port: b_in  input  1  borrow-in.
REQ-009 Port: diff  output  WIDTH  difference.
REQ-010 Port: b_out  output  1  borrow-out.
REQ-011 Port: done_valid  output  1  diff/b_out valid.
REQ-012 Port: done_ready  input  1  consumer takes result.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 The block SHALL assert start_ready only in IDLE.
REQ-015 On a rising edge with start_valid && start_ready, the block SHALL capture a, b, b_in into internal shift registers, clear the bit counter, and enter RUN.
REQ-016 In RUN, the block SHALL process one bit per cycle, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 The block SHALL shift each d into the result register from the MSB end so that after WIDTH RUN cycles bit i sits at diff[i].
REQ-018 The block SHALL leave RUN for DONE on the edge that processes bit WIDTH-1; done_valid first high exactly WIDTH cycles after the accepting edge.
REQ-019 The result SHALL be diff = (a - b - b_in) mod 2^WIDTH, b_out = 1 iff a < b + b_in (unsigned).
REQ-020 In DONE, the block SHALL hold done_valid high and diff/b_out stable until done_ready is sampled high, then return to IDLE on that edge.
REQ-021 start_valid arriving in the same cycle as a DONE->IDLE handshake SHALL NOT be accepted; acceptance SHALL occur at the earliest on the following edge.
REQ-022 Changes on a, b, b_in, start_valid during RUN or DONE SHALL have no effect.
REQ-023 done_ready while not in DONE SHALL be ignored.
REQ-024 diff and b_out SHALL only change on entry to DONE; they SHALL hold their last value in IDLE and RUN.

Reset
REQ-025 While rst_n is low, the block SHALL be in IDLE with diff = 0, b_out = 0, done_valid = 0, start_ready = 1, counter and shift registers = 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately with no result delivered.
REQ-027 The first acceptance after deassertion SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-028 Macro SERIAL_SUB_OVF_EN defined: the block SHALL add output port ovf (1 bit, reset 0), updated with diff, high iff a[MSB] != b[MSB] and diff[MSB] != a[MSB] (signed overflow, b_in included in the result).
REQ-029 Macro SERIAL_SUB_OVF_EN undefined: the ovf port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 The FSM state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) SHALL live in shared package serial_sub_pkg, along with the counter-width constant derived from WIDTH.
REQ-031 The one-bit borrow logic SHALL be a sub-module full_subtractor (ports x, y, bin, d, bout), instantiated once.

Verification
REQ-032 a=4'b1101, b=4'b1001, b_in=1 -> diff=4'b0011, b_out=0, done_valid 4 cycles after accept.
REQ-033 a=4'b0011, b=4'b1000, b_in=1 -> diff=4'b1010, b_out=1.
REQ-034 a=4'b0000, b=4'b0001, b_in=0 -> diff=4'b1111, b_out=1; then done_ready held low 5 cycles -> done_valid and diff stable throughout, start_valid ignored.
REQ-035 rst_n pulsed low at RUN cycle 2 -> done_valid never rises, outputs zero, start_ready=1; the next operation 4'b0101-4'b0010, b_in=0 -> diff=4'b0011, b_out=0.
REQ-036 With SERIAL_SUB_OVF_EN: a=4'b0111, b=4'b1111, b_in=0 -> diff=4'b1000, b_out=1, ovf=1; a=4'b0101, b=4'b0011 -> ovf=0.
REQ-037 Back-to-back: done_ready=1 and start_valid=1 held continuously -> one accept every WIDTH+2 cycles, no dropped or duplicated results.
